counter_wif: RTL and testbench



---
 rtl/counter_wif_if.sv | 25 ++
 rtl/counter_wif.sv | 59 +++++
 tb/tb_counter_wif.sv | 114 +++++++++++
 3 files changed

// File: rtl/counter_wif_if.sv
// rtl/counter_wif_if.sv - signal bundle for counter_wif; inputs start at 0 so an undriven bench holds.
interface counter_if #(
  parameter int WIDTH = 8
) (
  input logic clk
);
  logic             srst_n = 1'b0;
  logic             load   = 1'b0;
  logic             up     = 1'b0;
  logic             down   = 1'b0;
  logic [WIDTH-1:0] data   = '0;
  logic             rollover;
  logic [WIDTH-1:0] count;

  modport dut (
    input  clk,
    input  srst_n,
    input  load,
    input  up,
    input  down,
    input  data,
    output rollover,
    output count
  );
endinterface

// File: rtl/counter_wif.sv
// rtl/counter_wif.sv - up/down counter with load and one-cycle wrap flag, all I/O through counter_if.
// Define COUNTER_SATURATE_EN to clamp at the ends instead of wrapping (rollover still pulses).
module counter_wif #(
  parameter int WIDTH = 8
) (
  counter_if.dut bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL = {WIDTH{1'b0}};

  logic [WIDTH-1:0] count_q, count_d;
  logic             rollover_q, rollover_d;

  always_comb begin
    count_d    = count_q;
    rollover_d = 1'b0;
    if (bus.load) begin
      count_d = bus.data;
    end else if (bus.up && !bus.down) begin
      if (count_q == MAX_VAL) begin
        rollover_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
        count_d    = MAX_VAL;
`else
        count_d    = MIN_VAL;
`endif
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (bus.down && !bus.up) begin
      if (count_q == MIN_VAL) begin
        rollover_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
        count_d    = MIN_VAL;
`else
        count_d    = MAX_VAL;
`endif
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // srst_n is active-high despite its name.
  always_ff @(posedge bus.clk) begin
    if (bus.srst_n) begin
      count_q    <= '0;
      rollover_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rollover_q <= rollover_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.rollover = rollover_q;

endmodule

// File: tb/tb_counter_wif.sv
// tb/tb_counter_wif.sv - directed scoreboard bench for counter_wif (WIDTH=8).
module tb_counter_wif;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  counter_if #(.WIDTH(8)) cif (.clk(clk));
  counter_wif #(.WIDTH(8)) dut (.bus(cif));

  typedef struct {
    logic [7:0] c;
    logic       r;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic step(input logic rst, input logic ld, input logic u, input logic d,
                      input logic [7:0] dat, input logic [7:0] ec, input logic er,
                      input string tag);
    exp_t e, got;
    string t;
    @(negedge clk);
    cif.srst_n = rst;
    cif.load   = ld;
    cif.up     = u;
    cif.down   = d;
    cif.data   = dat;
    e.c = ec;
    e.r = er;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    t   = tag_q.pop_front();
    checks++;
    assert (cif.count === got.c) else begin
      errors++;
      $error("FAIL %s count: observed=%h expected=%h", t, cif.count, got.c);
    end
    checks++;
    assert (cif.rollover === got.r) else begin
      errors++;
      $error("FAIL %s rollover: observed=%b expected=%b", t, cif.rollover, got.r);
    end
  endtask

  initial begin
    // reset held with up (and once with load) active
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 8'h00, 8'h00, 0, "reset_up");
    step(1, 1, 0, 0, 8'h55, 8'h00, 0, "reset_over_load");

    for (int i = 1; i <= 10; i++) step(0, 0, 1, 0, 8'h00, 8'(i), 0, "count_up");
    for (int i = 9; i >= 5; i--)  step(0, 0, 0, 1, 8'h00, 8'(i), 0, "count_down");
    step(0, 0, 0, 0, 8'h00, 8'h05, 0, "idle_hold");

    // glitch on up between edges must not register
    @(negedge clk);
    cif.up = 1'b1;
    #2;
    cif.up = 1'b0;
    step(0, 0, 0, 0, 8'h00, 8'h05, 0, "glitch_ignored");

    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 8'hAA, 8'hAA, 0, "load_aa_up");
    step(0, 1, 0, 1, 8'hAA, 8'hAA, 0, "load_aa_down");

    step(0, 1, 0, 0, 8'hFE, 8'hFE, 0, "load_fe");
    step(0, 0, 1, 0, 8'h00, 8'hFF, 0, "up_to_ff");
    step(0, 0, 1, 0, 8'h00, SAT ? 8'hFF : 8'h00, 1, "up_wrap");
    step(0, 0, 1, 0, 8'h00, SAT ? 8'hFF : 8'h01, SAT, "up_after_wrap");
    step(0, 0, 0, 0, 8'h00, SAT ? 8'hFF : 8'h01, 0, "hold_after_wrap");

    step(0, 1, 0, 0, 8'h00, 8'h00, 0, "load_00");
    step(0, 0, 0, 1, 8'h00, SAT ? 8'h00 : 8'hFF, 1, "down_wrap");
    step(0, 0, 0, 0, 8'h00, SAT ? 8'h00 : 8'hFF, 0, "hold_after_down_wrap");
    step(0, 1, 0, 0, 8'hFF, 8'hFF, 0, "load_over_wrap");

    step(0, 1, 0, 0, 8'h37, 8'h37, 0, "load_37");
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 8'h00, 8'h37, 0, "up_and_down");
    step(1, 0, 1, 0, 8'h00, 8'h00, 0, "mid_reset");
    step(0, 0, 1, 0, 8'h00, 8'h01, 0, "resume_after_reset");

    // continuous up across one wrap
    step(0, 1, 0, 0, 8'hFD, 8'hFD, 0, "load_fd");
    step(0, 0, 1, 0, 8'h00, 8'hFE, 0, "run_fe");
    step(0, 0, 1, 0, 8'h00, 8'hFF, 0, "run_ff");
    step(0, 0, 1, 0, 8'h00, SAT ? 8'hFF : 8'h00, 1, "run_wrap");
    step(0, 0, 1, 0, 8'h00, SAT ? 8'hFF : 8'h01, SAT, "run_post1");
    step(0, 0, 1, 0, 8'h00, SAT ? 8'hFF : 8'h02, SAT, "run_post2");

    // mid-range decrement across a nibble boundary
    step(0, 1, 0, 0, 8'h10, 8'h10, 0, "load_10");
    step(0, 0, 0, 1, 8'h00, 8'h0F, 0, "down_0f");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
